intr_ctrl: RTL and testbench

Interrupt controller that sits directly upstream of the CPU control unit. It latches external interrupt requests and tracks which interrupts are in service. It drives the control unit's `min_bit_s` (highest-priority pending request) and `min_bit_a` (highest-priority interrupt in service). It consumes the control unit's `s_call_intr` / `s_return_intr` / `s_intr` strobes as acknowledge and end-of-interrupt.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/intr_edge_det.sv | 71 +++++++
 rtl/intr_ctrl.sv | 64 ++++++
 tb/tb_intr_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: interrupt width and one-hot priority helper.
// Latency: none (combinational helpers only).
// Backpressure: none.
package cpu_pkg;

  // Width of the interrupt request and min_bit_* buses shared with the control unit.
  localparam int N_INTR = 8;

  // Isolate the lowest set bit; bit 0 is the highest priority.
  function automatic logic [N_INTR-1:0] lowest_set(input logic [N_INTR-1:0] x);
    return x & (-x);
  endfunction

endpackage

// File: rtl/intr_edge_det.sv
// Per-line rising-edge detector with optional two-flop synchronizer (INTR_SYNC_EN).
// Latency: req asserts in the cycle irq is sampled high (two cycles later with INTR_SYNC_EN).
// Backpressure: none; req is a single-cycle pulse per 0->1 transition.
module intr_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic req
);

`ifdef INTR_SYNC_EN
  // Detection is armed once prev_q holds a post-reset sample of the line.
  localparam logic [1:0] ARM_LAST = 2'd3;

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic samp;

  // Two-flop synchronizer shift.
  always_comb begin
    sync1_d = irq;
    sync2_d = sync1_q;
  end

  // Synchronizer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign samp = sync2_q;
`else
  localparam logic [1:0] ARM_LAST = 2'd1;

  logic samp;

  assign samp = irq;
`endif

  logic       prev_q, prev_d;
  logic [1:0] arm_q, arm_d;

  // Track previous sample and count edges until the first real sample is held,
  // so a line already high at reset release does not look like a new request.
  always_comb begin
    prev_d = samp;
    arm_d  = arm_q;
    if (arm_q != ARM_LAST) begin
      arm_d = arm_q + 2'd1;
    end
  end

  // Edge-detect and arm state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
      arm_q  <= 2'd0;
    end else begin
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

  assign req = (arm_q == ARM_LAST) & samp & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches irq edges, tracks in-service set, reports one-hot priorities.
// Latency: request visible on min_bit_s after its sampling edge (+2 edges with INTR_SYNC_EN).
// Backpressure: none; acks/EOIs act on the edge they are strobed, outputs come from flops only.
module intr_ctrl #(
  parameter int N_INTR = cpu_pkg::N_INTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_INTR-1:0] irq,
  input  logic              mask_we,
  input  logic [N_INTR-1:0] mask_din,
  input  logic              s_intr,
  input  logic [N_INTR-1:0] s_call_intr,
  input  logic [N_INTR-1:0] s_return_intr,
  output logic [N_INTR-1:0] min_bit_s,
  output logic [N_INTR-1:0] min_bit_a,
  output logic [N_INTR-1:0] mask_q
);

  import cpu_pkg::lowest_set;

  logic [N_INTR-1:0] req;
  logic [N_INTR-1:0] ack;
  logic [N_INTR-1:0] eoi;
  logic [N_INTR-1:0] pending_q, pending_d;
  logic [N_INTR-1:0] in_service_q, in_service_d;
  logic [N_INTR-1:0] mask_d;

  for (genvar i = 0; i < N_INTR; i++) begin : g_edge
    intr_edge_det u_edge_det (
      .clk   (clk),
      .reset (reset),
      .irq   (irq[i]),
      .req   (req[i])
    );
  end

  // Next-state: new edges win over an ack on the same bit, acks win over EOI.
  always_comb begin
    ack          = s_intr ? s_call_intr   : '0;
    eoi          = s_intr ? s_return_intr : '0;
    pending_d    = (pending_q & ~ack) | req;
    in_service_d = (in_service_q & ~eoi) | ack;
    mask_d       = mask_we ? mask_din : mask_q;
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
    end
  end

  // Priority outputs depend on registers only, so no input-to-output path exists.
  assign min_bit_s = lowest_set(pending_q & mask_q & ~in_service_q);
  assign min_bit_a = lowest_set(in_service_q);

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Request latency in edges from driving irq follows INTR_SYNC_EN.
module tb_intr_ctrl;

`ifdef INTR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] irq;
  logic       mask_we;
  logic [7:0] mask_din;
  logic       s_intr;
  logic [7:0] s_call_intr;
  logic [7:0] s_return_intr;
  logic [7:0] min_bit_s;
  logic [7:0] min_bit_a;
  logic [7:0] mask_q;

  int checks;
  int failures;

  intr_ctrl #(.N_INTR(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq           (irq),
    .mask_we       (mask_we),
    .mask_din      (mask_din),
    .s_intr        (s_intr),
    .s_call_intr   (s_call_intr),
    .s_return_intr (s_return_intr),
    .min_bit_s     (min_bit_s),
    .min_bit_a     (min_bit_a),
    .mask_q        (mask_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack(input logic [7:0] v);
    s_intr = 1'b1;
    s_call_intr = v;
    tick(1);
    s_intr = 1'b0;
    s_call_intr = 8'h00;
  endtask

  task automatic do_eoi(input logic [7:0] v);
    s_intr = 1'b1;
    s_return_intr = v;
    tick(1);
    s_intr = 1'b0;
    s_return_intr = 8'h00;
  endtask

  task automatic do_mask(input logic [7:0] v);
    mask_we = 1'b1;
    mask_din = v;
    tick(1);
    mask_we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    irq = 8'h00;
    mask_we = 1'b0;
    mask_din = 8'h00;
    s_intr = 1'b0;
    s_call_intr = 8'h00;
    s_return_intr = 8'h00;
    tick(2);
    checks++;
    if (min_bit_s !== 8'h00 || min_bit_a !== 8'h00 || mask_q !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: s=%h a=%h mask=%h, required 00 00 00", min_bit_s, min_bit_a, mask_q);
    end
    reset = 1'b1;
    tick(5);
  endtask

  task automatic test_mask;
    irq = 8'h01;
    tick(LAT + 1);
    checks++;
    if (min_bit_s !== 8'h00) begin
      failures++;
      $display("FAIL masked_req: min_bit_s=%h required 00", min_bit_s);
    end
    do_mask(8'hFF);
    checks++;
    if (min_bit_s !== 8'h01 || mask_q !== 8'hFF) begin
      failures++;
      $display("FAIL unmask: s=%h mask=%h, required 01 ff", min_bit_s, mask_q);
    end
    do_ack(8'h01);
    checks++;
    if (min_bit_s !== 8'h00 || min_bit_a !== 8'h01) begin
      failures++;
      $display("FAIL ack_bit0: s=%h a=%h, required 00 01", min_bit_s, min_bit_a);
    end
    do_eoi(8'h01);
    checks++;
    if (min_bit_a !== 8'h00) begin
      failures++;
      $display("FAIL eoi_bit0: min_bit_a=%h required 00", min_bit_a);
    end
    irq = 8'h00;
    tick(LAT + 1);
  endtask

  task automatic test_priority;
    irq = 8'h24;
    tick(LAT);
    checks++;
    if (min_bit_s !== 8'h04) begin
      failures++;
      $display("FAIL prio_pick: min_bit_s=%h required 04", min_bit_s);
    end
    do_ack(8'h04);
    checks++;
    if (min_bit_s !== 8'h20 || min_bit_a !== 8'h04) begin
      failures++;
      $display("FAIL prio_after_ack: s=%h a=%h, required 20 04", min_bit_s, min_bit_a);
    end
    s_intr = 1'b1;
    s_call_intr = 8'h20;
    s_return_intr = 8'h04;
    tick(1);
    s_intr = 1'b0;
    s_call_intr = 8'h00;
    s_return_intr = 8'h00;
    checks++;
    if (min_bit_s !== 8'h00 || min_bit_a !== 8'h20) begin
      failures++;
      $display("FAIL ack_and_eoi_diff_bits: s=%h a=%h, required 00 20", min_bit_s, min_bit_a);
    end
    do_eoi(8'h20);
    checks++;
    if (min_bit_a !== 8'h00) begin
      failures++;
      $display("FAIL prio_cleanup: min_bit_a=%h required 00", min_bit_a);
    end
    irq = 8'h00;
    tick(LAT + 1);
  endtask

  task automatic test_nesting;
    irq = 8'h10;
    tick(LAT);
    do_ack(8'h10);
    checks++;
    if (min_bit_a !== 8'h10 || min_bit_s !== 8'h00) begin
      failures++;
      $display("FAIL nest_outer: s=%h a=%h, required 00 10", min_bit_s, min_bit_a);
    end
    irq = 8'h12;
    tick(LAT);
    checks++;
    if (min_bit_s !== 8'h02 || min_bit_a !== 8'h10) begin
      failures++;
      $display("FAIL nest_req: s=%h a=%h, required 02 10", min_bit_s, min_bit_a);
    end
    do_ack(8'h02);
    checks++;
    if (min_bit_a !== 8'h02 || min_bit_s !== 8'h00) begin
      failures++;
      $display("FAIL nest_inner: s=%h a=%h, required 00 02", min_bit_s, min_bit_a);
    end
    do_eoi(8'h02);
    checks++;
    if (min_bit_a !== 8'h10) begin
      failures++;
      $display("FAIL nest_return: min_bit_a=%h required 10", min_bit_a);
    end
    do_eoi(8'h10);
    checks++;
    if (min_bit_a !== 8'h00) begin
      failures++;
      $display("FAIL nest_cleanup: min_bit_a=%h required 00", min_bit_a);
    end
    irq = 8'h00;
    tick(LAT + 1);
  endtask

  task automatic test_level;
    int bad;
    irq = 8'h08;
    tick(LAT);
    checks++;
    if (min_bit_s !== 8'h08) begin
      failures++;
      $display("FAIL level_first: min_bit_s=%h required 08", min_bit_s);
    end
    do_ack(8'h08);
    bad = 0;
    for (int i = 0; i < 18; i++) begin
      tick(1);
      checks++;
      if (min_bit_s !== 8'h00) begin
        failures++;
        $display("FAIL level_single_req: cycle %0d min_bit_s=%h required 00", i, min_bit_s);
      end
    end
    do_eoi(8'h08);
    checks++;
    if (min_bit_s !== 8'h00 || min_bit_a !== 8'h00) begin
      failures++;
      $display("FAIL level_no_repeat: s=%h a=%h, required 00 00", min_bit_s, min_bit_a);
    end
    irq = 8'h00;
    tick(LAT + 1);
  endtask

  task automatic test_collision;
    irq = 8'h01;
    tick(LAT);
    checks++;
    if (min_bit_s !== 8'h01) begin
      failures++;
      $display("FAIL coll_first_req: min_bit_s=%h required 01", min_bit_s);
    end
    irq = 8'h00;
    tick(1);
    irq = 8'h01;
    tick(LAT - 1);
    do_ack(8'h01);
    checks++;
    if (min_bit_s !== 8'h00 || min_bit_a !== 8'h01) begin
      failures++;
      $display("FAIL edge_with_ack: s=%h a=%h, required 00 01", min_bit_s, min_bit_a);
    end
    do_eoi(8'h01);
    checks++;
    if (min_bit_s !== 8'h01 || min_bit_a !== 8'h00) begin
      failures++;
      $display("FAIL new_req_survives: s=%h a=%h, required 01 00", min_bit_s, min_bit_a);
    end
    s_intr = 1'b1;
    s_call_intr = 8'h01;
    tick(1);
    s_call_intr = 8'h00;
    s_return_intr = 8'h01;
    tick(1);
    s_intr = 1'b0;
    s_return_intr = 8'h00;
    checks++;
    if (min_bit_s !== 8'h00 || min_bit_a !== 8'h00) begin
      failures++;
      $display("FAIL coll_cleanup: s=%h a=%h, required 00 00", min_bit_s, min_bit_a);
    end
    s_intr = 1'b1;
    s_call_intr = 8'h40;
    s_return_intr = 8'h40;
    tick(1);
    s_intr = 1'b0;
    s_call_intr = 8'h00;
    s_return_intr = 8'h00;
    checks++;
    if (min_bit_a !== 8'h40) begin
      failures++;
      $display("FAIL ack_eoi_same_bit: min_bit_a=%h required 40", min_bit_a);
    end
    do_eoi(8'h40);
    irq = 8'h00;
    tick(LAT + 1);
  endtask

  task automatic test_async_reset;
    irq = 8'h01;
    tick(LAT);
    do_ack(8'h01);
    irq = 8'h0D;
    tick(LAT);
    checks++;
    if (min_bit_s !== 8'h04 || min_bit_a !== 8'h01) begin
      failures++;
      $display("FAIL pre_reset: s=%h a=%h, required 04 01", min_bit_s, min_bit_a);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (min_bit_s !== 8'h00 || min_bit_a !== 8'h00 || mask_q !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: s=%h a=%h mask=%h, required 00 00 00", min_bit_s, min_bit_a, mask_q);
    end
    tick(1);
    reset = 1'b1;
    do_mask(8'hFF);
    tick(5);
    checks++;
    if (min_bit_s !== 8'h00) begin
      failures++;
      $display("FAIL high_at_release: min_bit_s=%h required 00", min_bit_s);
    end
    irq = 8'h00;
    tick(LAT + 1);
    irq = 8'h08;
    tick(LAT);
    checks++;
    if (min_bit_s !== 8'h08) begin
      failures++;
      $display("FAIL req_after_release: min_bit_s=%h required 08", min_bit_s);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_mask;
    test_priority;
    test_nesting;
    test_level;
    test_collision;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
